// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bundle of the regfile_sb register file: read ports,
// busy flags, issue marking and writeback.
interface regfile_sb_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic            rs1_valid;
   logic            rs2_valid;
   logic [XLEN-1:0] src1_value;
   logic [XLEN-1:0] src2_value;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic [AW-1:0]   rd;
   logic            wr_en;
   logic [XLEN-1:0] result;
   logic            clr_busy;

   modport master (
      output rs1, rs2, rs1_valid, rs2_valid, issue_en, issue_rd,
             rd, wr_en, result, clr_busy,
      input  src1_value, src2_value, rs1_busy, rs2_busy
   );

   modport slave (
      input  rs1, rs2, rs1_valid, rs2_valid, issue_en, issue_rd,
             rd, wr_en, result, clr_busy,
      output src1_value, src2_value, rs1_busy, rs2_busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port and a busy
// scoreboard. Optional write-to-read bypass is enabled by REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy;
   logic [XLEN-1:0]  src1_reg;
   logic [XLEN-1:0]  src2_reg;
   logic [XLEN-1:0]  src1_next;
   logic [XLEN-1:0]  src2_next;

   // Register 0 has no storage: it always reads zero and is never busy.
   assign mem[0]  = '0;
   assign busy[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
         logic [XLEN-1:0] data_reg;
         logic            busy_reg;
         logic            wr_hit;
         logic            set_hit;
         logic            clr_hit;

         assign wr_hit  = bus.wr_en && (bus.rd == AW'(gi));
         assign set_hit = bus.issue_en && (bus.issue_rd == AW'(gi));
         assign clr_hit = wr_hit && bus.clr_busy;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg <= '0;
               busy_reg <= 1'b0;
            end else begin
               if (wr_hit)
                  data_reg <= bus.result;
               // A newly issued producer outranks the retiring one.
               if (set_hit)
                  busy_reg <= 1'b1;
               else if (clr_hit)
                  busy_reg <= 1'b0;
            end
         end

         assign mem[gi]  = data_reg;
         assign busy[gi] = busy_reg;
      end
   endgenerate

   function automatic logic [XLEN-1:0] read_value(input logic [AW-1:0] addr);
      logic [XLEN-1:0] value;
      value = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && (addr == bus.rd))
         value = bus.result;
`endif
      if (addr == '0)
         value = '0;
      return value;
   endfunction

   always_comb begin
      src1_next = src1_reg;
      src2_next = src2_reg;
      if (bus.rs1_valid)
         src1_next = read_value(bus.rs1);
      if (bus.rs2_valid)
         src2_next = read_value(bus.rs2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src1_reg <= '0;
         src2_reg <= '0;
      end else begin
         src1_reg <= src1_next;
         src2_reg <= src2_next;
      end
   end

   assign bus.src1_value = src1_reg;
   assign bus.src2_value = src2_reg;
   assign bus.rs1_busy   = busy[bus.rs1];
   assign bus.rs2_busy   = busy[bus.rs2];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb; the same-cycle read/write step
// expects bypassed data only when REGFILE_BYPASS_EN is defined.
module tb_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   // Apply the current inputs across one rising edge, then settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rs1_valid = 1'b0;
      bus.rs2_valid = 1'b0;
      bus.issue_en  = 1'b0;
      bus.wr_en     = 1'b0;
      bus.clr_busy  = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      bus.rs1 = '0; bus.rs2 = '0; bus.issue_rd = '0; bus.rd = '0; bus.result = '0;
      idle();

      #3;
      check("rst_src1", bus.src1_value, 32'h0);
      check("rst_src2", bus.src2_value, 32'h0);
      check("rst_busy1", {31'h0, bus.rs1_busy}, 32'h0);
      #9 rst_n = 1'b1;
      #2;

      // Read after reset
      bus.rs1 = 5'd5; bus.rs2 = 5'd31; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
      step();
      check("rd5_src1", bus.src1_value, 32'h0);
      check("rd31_src2", bus.src2_value, 32'h0);
      check("rd_busy1", {31'h0, bus.rs1_busy}, 32'h0);
      check("rd_busy2", {31'h0, bus.rs2_busy}, 32'h0);

      // Write then read
      idle();
      bus.wr_en = 1'b1; bus.rd = 5'd3; bus.result = 32'hDEADBEEF;
      step();
      idle();
      bus.rs1 = 5'd3; bus.rs1_valid = 1'b1;
      step();
      check("wr3_rd", bus.src1_value, 32'hDEADBEEF);

      // Write to r0 is dropped, same-cycle and later
      idle();
      bus.wr_en = 1'b1; bus.rd = 5'd0; bus.result = 32'h1234;
      bus.rs2 = 5'd0; bus.rs2_valid = 1'b1;
      step();
      check("r0_same", bus.src2_value, 32'h0);
      bus.wr_en = 1'b0;
      step();
      check("r0_after", bus.src2_value, 32'h0);

      // Same-cycle write/read of r7
      idle();
      bus.wr_en = 1'b1; bus.rd = 5'd7; bus.result = 32'h11;
      step();
      bus.result = 32'hA5A5A5A5; bus.rs1 = 5'd7; bus.rs1_valid = 1'b1;
      step();
`ifdef REGFILE_BYPASS_EN
      check("r7_same", bus.src1_value, 32'hA5A5A5A5);
`else
      check("r7_same", bus.src1_value, 32'h11);
`endif
      bus.wr_en = 1'b0;
      step();
      check("r7_next", bus.src1_value, 32'hA5A5A5A5);

      // Scoreboard: set, no early clear, clear, set-wins, data-only write
      idle();
      bus.issue_en = 1'b1; bus.issue_rd = 5'd9; bus.rs1 = 5'd9; bus.rs2 = 5'd9;
      #1;
      check("sb_pre_set", {31'h0, bus.rs1_busy}, 32'h0);
      step();
      check("sb_set1", {31'h0, bus.rs1_busy}, 32'h1);
      check("sb_set2", {31'h0, bus.rs2_busy}, 32'h1);
      idle();
      bus.wr_en = 1'b1; bus.clr_busy = 1'b1; bus.rd = 5'd9; bus.result = 32'h99;
      #1;
      check("sb_no_fwd", {31'h0, bus.rs1_busy}, 32'h1);
      step();
      check("sb_clr", {31'h0, bus.rs1_busy}, 32'h0);
      bus.issue_en = 1'b0; bus.wr_en = 1'b0; bus.clr_busy = 1'b0;
      bus.issue_en = 1'b1;
      step();
      bus.wr_en = 1'b1; bus.clr_busy = 1'b1;
      step();
      check("sb_set_wins", {31'h0, bus.rs1_busy}, 32'h1);
      idle();
      bus.wr_en = 1'b1; bus.clr_busy = 1'b0; bus.rd = 5'd9;
      step();
      check("sb_data_only", {31'h0, bus.rs1_busy}, 32'h1);
      idle();
      bus.issue_en = 1'b1; bus.issue_rd = 5'd0; bus.rs1 = 5'd0;
      step();
      check("sb_r0", {31'h0, bus.rs1_busy}, 32'h0);

      // Hold when read enable drops
      idle();
      bus.wr_en = 1'b1; bus.rd = 5'd4; bus.result = 32'h55;
      step();
      idle();
      bus.rs2 = 5'd4; bus.rs2_valid = 1'b1;
      step();
      check("hold_load", bus.src2_value, 32'h55);
      bus.rs2_valid = 1'b0; bus.rs2 = 5'd6;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("hold_%0d", i), bus.src2_value, 32'h55);
      end

      // Asynchronous reset mid-cycle
      idle();
      bus.wr_en = 1'b1; bus.rd = 5'd12; bus.result = 32'hFF;
      bus.issue_en = 1'b1; bus.issue_rd = 5'd12;
      step();
      idle();
      bus.rs1 = 5'd12; bus.rs2 = 5'd12; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
      step();
      check("r12_src1", bus.src1_value, 32'hFF);
      check("r12_busy", {31'h0, bus.rs1_busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_src1", bus.src1_value, 32'h0);
      check("arst_src2", bus.src2_value, 32'h0);
      check("arst_busy", {31'h0, bus.rs1_busy}, 32'h0);
      idle();
      #14 rst_n = 1'b1;
      #2;
      bus.rs1 = 5'd12; bus.rs1_valid = 1'b1;
      step();
      check("post_rst_r12", bus.src1_value, 32'h0);
      check("post_rst_bsy", {31'h0, bus.rs1_busy}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
